// File: rtl/fifo_controller.sv
// fifo_controller
// Sequencer and arbiter for the capture FIFO. Converts writer/reader
// request traffic into single-cycle push/pop strobes, tracks occupancy,
// and drives the FIFO clear/enable pins for frame start and stop.
//
// Ports:
//   clock, reset_n        system clock (rising edge), async active-low reset
//   start, stop           frame control pulses (start wins if both)
//   wr_req/wr_data/wr_ack writer handshake, wr_ack is a one-cycle pulse
//   rd_req/rd_data/rd_valid reader handshake, rd_valid is a one-cycle pulse
//   level, full, empty    registered occupancy
//   busy                  controller is not OFF
//   fifo_enable, fifo_clear, fifo_push, fifo_pop, fifo_in_data  to FIFO
//   fifo_out_data         from FIFO
//
// State table:
//   ST_OFF   | disabled, requests ignored, waits for start
//   ST_CLEAR | fifo_clear held for CLEAR_CYCLES cycles
//   ST_IDLE  | enabled, arbitrating, nothing granted last cycle
//   ST_PUSH  | push strobe high, wr_ack high
//   ST_POP   | pop strobe high
//   ST_GAP   | strobes low after an operation, arbitrating, rd_valid after pop
module fifo_controller #(
  parameter int FIFO_SIZE    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           wr_req,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           wr_ack,
  input  logic                           rd_req,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [$clog2(FIFO_SIZE+1)-1:0] level,
  output logic                           full,
  output logic                           empty,
  output logic                           busy,
  output logic                           fifo_enable,
  output logic                           fifo_clear,
  output logic                           fifo_push,
  output logic                           fifo_pop,
  output logic [DATA_WIDTH-1:0]          fifo_in_data,
  input  logic [DATA_WIDTH-1:0]          fifo_out_data
);

  localparam int LW = $clog2(FIFO_SIZE + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(FIFO_SIZE);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_CLEAR,
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_GAP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   clr_cnt;
  logic            stop_pend;
  logic            last_grant_push;
  logic            push_ok, pop_ok, grant_push, grant_pop;
  logic [LW-1:0]   level_nxt;

  assign push_ok    = wr_req && !full;
  assign pop_ok     = rd_req && !empty;
  // On a tie the side that did not win last time goes first.
  assign grant_push = push_ok && (!pop_ok || !last_grant_push);
  assign grant_pop  = pop_ok && !grant_push;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (start)             state_nxt = ST_CLEAR;
        else if (clr_cnt == '0) state_nxt = ST_IDLE;
      end
      ST_IDLE, ST_GAP: begin
        if (start)                  state_nxt = ST_CLEAR;
        else if (stop || stop_pend) state_nxt = ST_OFF;
        else if (grant_push)        state_nxt = ST_PUSH;
        else if (grant_pop)         state_nxt = ST_POP;
        else                        state_nxt = ST_IDLE;
      end
      ST_PUSH, ST_POP: begin
        state_nxt = start ? ST_CLEAR : ST_GAP;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    level_nxt = level;
    if (state_nxt == ST_CLEAR)  level_nxt = '0;
    else if (state == ST_PUSH)  level_nxt = level + LW'(1);
    else if (state == ST_POP)   level_nxt = level - LW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_OFF;
      clr_cnt         <= '0;
      stop_pend       <= 1'b0;
      last_grant_push <= 1'b0;
      level           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      rd_data         <= '0;
      rd_valid        <= 1'b0;
      wr_ack          <= 1'b0;
      fifo_push       <= 1'b0;
      fifo_pop        <= 1'b0;
      fifo_in_data    <= '0;
      fifo_clear      <= 1'b0;
      fifo_enable     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state <= state_nxt;

      // Reload on entry and on a repeated start; count down while clearing.
      if (state_nxt == ST_CLEAR && (state != ST_CLEAR || start))
        clr_cnt <= CLR_LOAD;
      else if (state == ST_CLEAR && clr_cnt != '0)
        clr_cnt <= clr_cnt - CW'(1);

      // A stop seen mid-operation is held until the following GAP.
      if (state_nxt == ST_OFF || state_nxt == ST_CLEAR)
        stop_pend <= 1'b0;
      else if ((state == ST_PUSH || state == ST_POP) && stop)
        stop_pend <= 1'b1;

      if (state_nxt == ST_PUSH)     last_grant_push <= 1'b1;
      else if (state_nxt == ST_POP) last_grant_push <= 1'b0;

      level <= level_nxt;
      full  <= (level_nxt == LVL_MAX);
      empty <= (level_nxt == '0);

      // A pop that completes as start arrives still delivers its word with
      // rd_valid; otherwise entering CLEAR zeroes the read register.
      if (state == ST_POP)
        rd_data <= fifo_out_data;
      else if (state_nxt == ST_CLEAR && state != ST_CLEAR)
        rd_data <= '0;
      rd_valid <= (state == ST_POP);

      wr_ack    <= (state_nxt == ST_PUSH);
      fifo_push <= (state_nxt == ST_PUSH);
      fifo_pop  <= (state_nxt == ST_POP);
      if (state_nxt == ST_PUSH) fifo_in_data <= wr_data;

      fifo_clear  <= (state_nxt == ST_CLEAR);
      fifo_enable <= (state_nxt == ST_IDLE) || (state_nxt == ST_PUSH) ||
                     (state_nxt == ST_POP)  || (state_nxt == ST_GAP);
      busy        <= (state_nxt != ST_OFF);
    end
  end

endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller
// Self-checking bench for fifo_controller. Contains a simple show-ahead
// FIFO model standing in for the capture FIFO, and a scoreboard queue of
// accepted write words that is compared against rd_data on every rd_valid.
module tb_fifo_controller;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, rd_valid, full, empty, busy;
  logic          fifo_enable, fifo_clear, fifo_push, fifo_pop;
  logic [DW-1:0] rd_data, fifo_in_data, fifo_out_data;
  logic [3:0]    level;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  fifo_controller #(.FIFO_SIZE(8), .DATA_WIDTH(DW), .CLEAR_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .level(level), .full(full), .empty(empty), .busy(busy),
    .fifo_enable(fifo_enable), .fifo_clear(fifo_clear),
    .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .fifo_in_data(fifo_in_data), .fifo_out_data(fifo_out_data)
  );

  always #5 clock = ~clock;

  // Show-ahead FIFO: out_data is the head word, advanced after each pop.
  logic [DW-1:0] mem [0:7];
  logic [2:0]    wp = '0, rp = '0;
  always @(posedge clock) begin
    if (fifo_clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_push) begin
        mem[wp] <= fifo_in_data;
        wp      <= wp + 3'd1;
      end
      if (fifo_pop) rp <= rp + 3'd1;
    end
  end
  assign fifo_out_data = mem[rp];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // which: 0 = wr_ack, 1 = rd_valid, 2 = fifo_pop
  task automatic wait_for(input int which, input string tag, output int n);
    logic sig;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      sig = (which == 0) ? wr_ack : (which == 1) ? rd_valid : fifo_pop;
    end while (!sig && n < 20);
    if (!sig) check_val({tag, "_timeout"}, 0, 1);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      check_val("push_pop_overlap", {31'b0, fifo_push & fifo_pop}, 0);
      if (rd_valid) begin
        if (exp_q.size() == 0) check_val("rd_unexpected", 1, 0);
        else                   check_val("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    bit seen;
    int ops;
    bit exp_push;

    repeat (2) @(negedge clock);
    check_val("rst_level", level, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_ctrl", {busy, fifo_enable, fifo_clear, fifo_push, fifo_pop, wr_ack, rd_valid}, 0);
    check_val("rst_data", rd_data | fifo_in_data, 0);

    reset_n = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_val("clr_c1", {fifo_clear, fifo_enable}, 2'b10);
    @(negedge clock);
    check_val("clr_c2", {fifo_clear, fifo_enable}, 2'b10);
    @(negedge clock);
    check_val("clr_done", {fifo_clear, fifo_enable}, 2'b01);
    check_val("clr_level", level, 0);
    check_val("clr_empty", empty, 1);

    // Eight back-to-back writes with wr_req held.
    wr_data = 32'hA0;
    wr_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_for(0, "wr", n);
      check_val(i == 0 ? "wr_latency" : "wr_spacing", n, i == 0 ? 1 : 2);
      exp_q.push_back(wr_data);
      wr_data = 32'hA0 + i + 1;
    end
    @(negedge clock);
    check_val("full_level", level, 8);
    check_val("full_flag", {full, empty}, 2'b10);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (wr_ack || fifo_push) seen = 1;
    end
    check_val("wr_blocked_full", seen, 0);
    wr_req = 1'b0;

    // Eight back-to-back reads with rd_req held.
    rd_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_for(1, "rd", n);
      check_val(i == 0 ? "rd_latency" : "rd_spacing", n, 2);
    end
    rd_req = 1'b0;
    check_val("empty_level", level, 0);
    check_val("empty_flag", {full, empty}, 2'b01);
    rd_req = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (rd_valid || fifo_pop) seen = 1;
    end
    check_val("rd_blocked_empty", seen, 0);
    rd_req = 1'b0;

    // Bring level to 4 with a pop as the most recent grant.
    wr_data = 32'hB0;
    wr_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_for(0, "wr_b", n);
      exp_q.push_back(wr_data);
      wr_data = wr_data + 1;
      if (i == 4) wr_req = 1'b0;
    end
    rd_req = 1'b1;
    wait_for(1, "rd_b", n);
    rd_req = 1'b0;
    check_val("tie_start_level", level, 4);

    // Both requests held: grants alternate starting with push.
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    ops      = 0;
    exp_push = 1'b1;
    for (int c = 0; c < 40 && ops < 8; c++) begin
      @(negedge clock);
      check_val("tie_level_range", {31'b0, level == 4 || level == 5}, 1);
      if (fifo_push || fifo_pop) begin
        check_val("tie_grant", fifo_push, exp_push);
        check_val("tie_level", level, fifo_push ? 4 : 5);
        if (wr_ack) begin
          exp_q.push_back(wr_data);
          wr_data = wr_data + 1;
        end
        exp_push = !exp_push;
        ops++;
      end
    end
    check_val("tie_ops", ops, 8);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (3) @(negedge clock);
    check_val("tie_end_level", level, 4);

    // Asynchronous reset while a pop strobe is high.
    rd_req = 1'b1;
    wait_for(2, "pop_mid", n);
    rd_req = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_val("arst_ctrl", {busy, fifo_enable, fifo_clear, fifo_push, fifo_pop, wr_ack, rd_valid}, 0);
    check_val("arst_level", level, 0);
    check_val("arst_flags", {full, empty}, 2'b01);
    check_val("arst_data", rd_data | fifo_in_data, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_val("restart_clear", {busy, fifo_clear, fifo_enable}, 3'b110);
    repeat (2) @(negedge clock);
    check_val("restart_enable", {fifo_clear, fifo_enable}, 2'b01);

    // stop during PUSH: operation completes, GAP, then OFF.
    wr_data = 32'hC0;
    wr_req  = 1'b1;
    wait_for(0, "wr_c", n);
    exp_q.push_back(wr_data);
    wr_req = 1'b0;
    stop   = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_val("stop_gap", {busy, fifo_enable, fifo_push}, 3'b110);
    check_val("stop_gap_level", level, 1);
    @(negedge clock);
    check_val("stop_off", {busy, fifo_enable}, 2'b00);
    check_val("stop_off_level", level, 1);
    check_val("stop_off_empty", empty, 0);
    wr_req = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (wr_ack || fifo_push) seen = 1;
    end
    check_val("off_ignores_req", seen, 0);
    wr_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_controller.md
Name: fifo_controller

Overview:
- Sequencer and arbiter for the capture FIFO. Runs on a single system clock.
- Turns request/acknowledge traffic from a pixel writer and a frame reader into clean single-cycle push and pop strobes. Push and pop are never asserted together.
- Tracks FIFO occupancy, blocks writes when full and reads when empty.
- Drives the FIFO clear/enable pins for frame start and stop.

Parameters:
FIFO_SIZE, 8, depth of the controlled FIFO in words
DATA_WIDTH, 32, data word width
CLEAR_CYCLES, 2, cycles fifo_clear is held high on start (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear FIFO, then enable operation
stop  in  1  pulse: finish current operation, then disable
wr_req  in  1  writer request; held until wr_ack
wr_data  in  DATA_WIDTH  word to write; stable while wr_req is high
wr_ack  out  1  one-cycle pulse: word accepted
rd_req  in  1  reader request; held until rd_valid
rd_data  out  DATA_WIDTH  popped word; held until next pop
rd_valid  out  1  one-cycle pulse: rd_data updated
level  out  $clog2(FIFO_SIZE+1)  words currently stored
full  out  1  level == FIFO_SIZE
empty  out  1  level == 0
busy  out  1  state != OFF
fifo_enable  out  1  to FIFO enable
fifo_clear  out  1  to FIFO clear
fifo_push  out  1  to FIFO push_clock
fifo_pop  out  1  to FIFO pop_clock
fifo_in_data  out  DATA_WIDTH  to FIFO in_data
fifo_out_data  in  DATA_WIDTH  from FIFO out_data

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous):
  - state = OFF.
  - These outputs go to 0: wr_ack, rd_valid, rd_data, level, fifo_enable, fifo_clear, fifo_push, fifo_pop, fifo_in_data, busy.
  - empty = 1, full = 0, last_grant = POP.
- States: OFF, CLEAR, IDLE, PUSH, POP, GAP.
- OFF:
  - fifo_enable = 0.
  - Requests are ignored (no ack).
  - start -> CLEAR.
- CLEAR:
  - fifo_clear = 1, fifo_enable = 0 for CLEAR_CYCLES cycles.
  - level <= 0 and rd_data <= 0 on entry.
  - Then -> IDLE with fifo_clear = 0 and fifo_enable = 1.
  - start while in CLEAR restarts the count. stop while in CLEAR is ignored.
- Arbitration (evaluated in IDLE and GAP only):
  - Push is eligible when wr_req = 1 and full = 0. Pop is eligible when rd_req = 1 and empty = 0.
  - One eligible -> grant it. Both eligible -> grant the opposite of last_grant, then update last_grant.
  - Grant push -> PUSH; grant pop -> POP; no grant -> IDLE.
- PUSH (one cycle):
  - fifo_push = 1; fifo_in_data = wr_data captured at the grant edge.
  - wr_ack = 1 for this cycle; level + 1 at the exit edge.
  - Then -> GAP. fifo_in_data holds its value until the next push.
- POP (one cycle):
  - fifo_pop = 1; level - 1 at the exit edge.
  - At the exit edge rd_data <= fifo_out_data. The FIFO updates out_data on the pop rising edge, so the value is settled by then.
  - Then -> GAP with rd_valid = 1 for one cycle.
- GAP:
  - fifo_push = fifo_pop = 0, which guarantees a low phase before the next strobe.
  - Arbitrates as in IDLE. Sustained throughput is one operation per 2 cycles.
  - Latency from request sampled to ack: 1 cycle for write (wr_ack in PUSH), 2 cycles for read (rd_valid in GAP).
- Requester handshake:
  - A requester must drop its request in the cycle after ack/valid.
  - A request still high in the GAP after its own ack is treated as a new request.
- Invariants: fifo_push and fifo_pop are never 1 in the same cycle. level never exceeds FIFO_SIZE and never underflows.
- stop:
  - In IDLE or GAP -> OFF next cycle.
  - In PUSH or POP: latched; the operation completes, GAP is still entered, then -> OFF.
  - On entering OFF: level and rd_data are retained, fifo_enable = 0.
- start:
  - Accepted in any state; start and stop in the same cycle -> start wins.
  - start during PUSH or POP: the strobe completes this cycle, wr_ack / rd_valid still pulse, then -> CLEAR. The cleared data is discarded.
- full and empty are derived from the registered level and update in the same cycle as level.

Test Plan:
- Reset, then start with CLEAR_CYCLES=2 -> fifo_clear high exactly 2 cycles; fifo_enable=1 from the 3rd cycle; level=0; empty=1.
- Write 0xA0..0xA7 back-to-back with wr_req held -> wr_ack every 2nd cycle; full=1 after the 8th; 9th request (0xA8) gets no ack until a pop occurs.
- Read 8 words from a full FIFO -> rd_valid every 2nd cycle with rd_data 0xA0..0xA7 in order; empty=1 after the last; a further rd_req gets no response.
- wr_req and rd_req held together at level=4 -> grants alternate push, pop, push, pop (first grant push after reset); fifo_push & fifo_pop never overlap; level stays 4/5.
- stop asserted in a PUSH cycle -> wr_ack still pulses, level increments, GAP, then OFF; fifo_enable=0; later requests ignored.
- reset_n low mid-POP -> all outputs 0 immediately (asynchronous); the next start begins again from CLEAR.
